data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the datapath's load/store interface. Accepts one word-wide read or write request at a time from the core and returns a response after a fixed number of wait states.
- Replaces the zero-latency data memory, so the core can be exercised against realistic memory timing.
- Holds the storage array internally, supports byte-lane writes, and flags bad addresses with an error response.

Parameters:
DEPTH_LOG2, 8, log2 of storage depth in 32-bit words (default 256 words = 1 KiB)
WAIT_STATES, 2, extra cycles between request acceptance and response; legal range 0..15

Ports:
Clk  input  1  clock, all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Req  input  1  request valid from core
ReqWrite  input  1  1 = write, 0 = read; sampled with Req
Address  input  32  byte address; must be word aligned
WriteData  input  32  store data
ByteEnable  input  4  write lane mask; bit i enables byte i = bits [8i+7:8i]; ignored for reads
ReqReady  output  1  responder can accept a request this cycle
RespValid  output  1  response available
RespReady  input  1  core accepts the response
ReadData  output  32  load data; 0 for write responses and for errors
RespError  output  1  request was misaligned or out of range
Busy  output  1  a transaction is in progress (state != IDLE)

Behaviour:
- Clocking and reset: single clock Clk. Reset is synchronous and active-high.
- While Reset is high at a rising edge:
  - state goes to IDLE and the wait counter clears;
  - RespValid, ReadData, RespError and Busy are all 0;
  - ReqReady is 0 while Reset is high and 1 from the first cycle after Reset goes low.
- Storage contents are not affected by Reset. For simulation they are zero-initialised at time 0.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady = 1, Busy = 0.
  - A request is accepted at an edge where Req && ReqReady.
  - On acceptance, Address, ReqWrite, WriteData and ByteEnable are captured.
  - Next state is WAIT with counter = WAIT_STATES − 1, or RESP directly if WAIT_STATES = 0.
- WAIT:
  - ReqReady = 0, Busy = 1.
  - The counter decrements each cycle; the state moves to RESP at the edge where the counter is 0.
- RESP entry edge (the only edge where storage changes):
  - Error check: error = (captured Address[1:0] != 0) OR (Address[31:2] >= 2^DEPTH_LOG2).
  - Error case: no storage update, RespError = 1, ReadData = 0.
  - Valid write: for each i with ByteEnable[i] = 1, byte i of the word is written; other bytes keep their old value. ReadData = 0.
  - Valid read: ReadData is the word contents at this edge.
  - A write with ByteEnable = 0000 is legal: no change, RespError = 0.
- RESP:
  - RespValid = 1, Busy = 1, ReqReady = 0.
  - ReadData and RespError are held stable until RespValid && RespReady is seen at an edge; state then returns to IDLE.
- Outputs in IDLE and WAIT: RespValid, ReadData and RespError read 0 in every cycle outside RESP.
- Latency: RespValid first asserts exactly WAIT_STATES+1 cycles after the accepting edge.
- Throughput: at best one transaction per WAIT_STATES+2 cycles. No request is accepted in the same cycle a response completes.
- Req during WAIT or RESP is ignored and not queued. The core must keep Req asserted until ReqReady.
- Reset mid-transaction:
  - In WAIT: the transaction is dropped and a pending write is never committed.
  - In RESP: the response is dropped; the write has already been committed.
- Address bits [31:DEPTH_LOG2+2] are not aliased. Any nonzero upper bit is out of range.
- WAIT_STATES > 15 is a configuration error. The counter is 4 bits.

Test Plan:
1. WAIT_STATES=2: write 0xDEADBEEF to 0x10 with BE=1111, then read 0x10.
   - Each RespValid rises 3 cycles after its accepting edge.
   - The read returns ReadData = 0xDEADBEEF, RespError = 0.
2. Byte lanes: write 0x11223344 with BE=0101 to 0x10 over 0xDEADBEEF.
   - Read of 0x10 returns 0xDE22BE44.
3. Errors:
   - Write to 0x13 gives RespError = 1, ReadData = 0, and a later read of 0x10 is unchanged.
   - Read of 0x400 (DEPTH_LOG2=8) gives RespError = 1, ReadData = 0.
4. Backpressure: hold RespReady = 0 for 5 cycles during a read of 0x10, with Req pulsed high meanwhile.
   - RespValid, ReadData and RespError stay stable, ReqReady = 0, and the extra Req is ignored.
   - IDLE is reached one cycle after RespReady = 1.
5. Reset mid-write: assert Reset during WAIT of a write 0xCAFEF00D to 0x20.
   - Busy = 0 and RespValid = 0 after that edge; ReqReady = 1 one cycle after Reset drops.
   - Read of 0x20 returns its old value 0x00000000.
6. WAIT_STATES=0 with RespReady tied to 1 and Req held high, alternating reads and writes.
   - RespValid is seen in the cycle after each accept.
   - Accepts occur every 2 cycles and data is correct throughout.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the core (master) and the data memory responder (slave).
interface data_mem_if;
  logic        Req;
  logic        ReqWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [3:0]  ByteEnable;
  logic        ReqReady;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] ReadData;
  logic        RespError;
  logic        Busy;

  modport slave (
    input  Req, ReqWrite, Address, WriteData, ByteEnable, RespReady,
    output ReqReady, RespValid, ReadData, RespError, Busy
  );

  modport master (
    output Req, ReqWrite, Address, WriteData, ByteEnable, RespReady,
    input  ReqReady, RespValid, ReadData, RespError, Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory responder: one request at a time, fixed wait states,
// byte-lane writes, and an error response for misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2   // 0..15; the wait counter is 4 bits
) (
  input  logic       Clk,
  input  logic       Reset,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_ok_q, rd_ok_d;
  logic        err_q, err_d;

  logic        req_ready;
  logic        enter_resp;
  logic        commit;
  logic [31:0] txn_addr;
  logic        txn_write;
  logic [31:0] txn_wdata;
  logic [3:0]  txn_be;
  logic        txn_err;
  logic [DEPTH_LOG2-1:0] txn_idx;
  logic [31:0] mem_rd;

  // With zero wait states RESP is entered on the accepting edge, before the
  // capture registers load, so the transaction is taken straight from the bus.
  always_comb begin
    txn_addr  = addr_q;
    txn_write = write_q;
    txn_wdata = wdata_q;
    txn_be    = be_q;
    if (state_q == IDLE) begin
      txn_addr  = bus.Address;
      txn_write = bus.ReqWrite;
      txn_wdata = bus.WriteData;
      txn_be    = bus.ByteEnable;
    end
  end

  assign txn_err = (txn_addr[1:0] != 2'b00) || (|txn_addr[31:DEPTH_LOG2+2]);
  assign txn_idx = txn_addr[DEPTH_LOG2+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_ok_d    = rd_ok_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !Reset;
        if (bus.Req && req_ready) begin
          addr_d  = bus.Address;
          write_d = bus.ReqWrite;
          wdata_d = bus.WriteData;
          be_d    = bus.ByteEnable;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.RespReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d   = txn_err;
      rd_ok_d = !txn_err && !txn_write;
    end
  end

  // Storage only changes on the RESP entry edge, and never on a reset edge.
  assign commit = enter_resp && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

  // One byte-wide array per lane so the lane mask maps onto block RAM byte enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH] = '{default: '0};
    logic [7:0] lane_rd_q;

    always_ff @(posedge Clk) begin
      if (commit && txn_write && !txn_err && txn_be[gi]) begin
        lane_mem[txn_idx] <= txn_wdata[8*gi +: 8];
      end
      if (commit) begin
        lane_rd_q <= lane_mem[txn_idx];
      end
    end

    assign mem_rd[8*gi +: 8] = lane_rd_q;
  end

  assign bus.ReqReady  = req_ready;
  assign bus.RespValid = (state_q == RESP);
  assign bus.ReadData  = (state_q == RESP && rd_ok_q) ? mem_rd : 32'd0;
  assign bus.RespError = (state_q == RESP) && err_q;
  assign bus.Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances,
// with a memory model feeding a scoreboard of expected responses.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_if a_if ();
  data_mem_if b_if ();

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (a_if)
  );

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (b_if)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] model_a [256];
  logic [31:0] model_b [256];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_access(input bit use_b, input logic wr,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be);
    exp_t        e;
    logic [31:0] w;
    int          idx;
    e.err  = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
    e.data = 32'd0;
    if (!e.err) begin
      idx = int'(addr[9:2]);
      w   = use_b ? model_b[idx] : model_a[idx];
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        if (use_b) model_b[idx] = w;
        else       model_a[idx] = w;
      end else begin
        e.data = w;
      end
    end
    return e;
  endfunction

  // One transaction on the WAIT_STATES=2 instance; hold > 0 withholds RespReady
  // for that many extra cycles and pulses a stray Req while the response waits.
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input string tag);
    exp_t e;
    int   lat;
    int   spins;
    @(negedge clk);
    a_if.Req        = 1'b1;
    a_if.ReqWrite   = wr;
    a_if.Address    = addr;
    a_if.WriteData  = wdata;
    a_if.ByteEnable = be;
    a_if.RespReady  = (hold == 0);
    spins = 0;
    while (!a_if.ReqReady && spins < 20) begin
      @(negedge clk);
      spins++;
    end
    check({tag, " req_ready"}, 32'(a_if.ReqReady), 32'd1);
    if (!a_if.ReqReady) begin
      a_if.Req = 1'b0;
      return;
    end
    @(posedge clk);
    sb_a.push_back(model_access(1'b0, wr, addr, wdata, be));
    #1 a_if.Req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, " wait busy"}, 32'(a_if.Busy), 32'd1);
        check({tag, " wait req_ready"}, 32'(a_if.ReqReady), 32'd0);
      end
    end while (!a_if.RespValid && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'd3);
    if (!a_if.RespValid) begin
      a_if.RespReady = 1'b1;
      return;
    end
    if (sb_a.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_a.pop_front();
    check({tag, " read_data"}, a_if.ReadData, e.data);
    check({tag, " resp_error"}, 32'(a_if.RespError), 32'(e.err));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_if.Req        = 1'b1;
        a_if.ReqWrite   = 1'b1;
        a_if.WriteData  = 32'hFFFF_FFFF;
        a_if.ByteEnable = 4'hF;
      end
      if (c == 2) a_if.Req = 1'b0;
      check($sformatf("%s hold%0d valid", tag, c), 32'(a_if.RespValid), 32'd1);
      check($sformatf("%s hold%0d data", tag, c), a_if.ReadData, e.data);
      check($sformatf("%s hold%0d err", tag, c), 32'(a_if.RespError), 32'(e.err));
      check($sformatf("%s hold%0d req_ready", tag, c), 32'(a_if.ReqReady), 32'd0);
    end
    a_if.RespReady = 1'b1;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(a_if.Busy), 32'd0);
    check({tag, " idle valid"}, 32'(a_if.RespValid), 32'd0);
    check({tag, " idle data"}, a_if.ReadData, 32'd0);
    check({tag, " idle req_ready"}, 32'(a_if.ReqReady), 32'd1);
    $display("A %s wr=%0b addr=0x%08h wdata=0x%08h be=%04b -> data=0x%08h err=%0b lat=%0d",
             tag, wr, addr, wdata, be, e.data, e.err, lat);
  endtask

  // Back-to-back stimulus table for the WAIT_STATES=0 instance.
  logic        b_wr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] b_addr [8] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h44, 32'h44, 32'h41, 32'h3FC};
  logic [31:0] b_data [8] = '{32'h1234_5678, 32'h0, 32'hAABB_CCDD, 32'h0,
                              32'h0F0F_0F0F, 32'h0, 32'h0, 32'h55AA_55AA};
  logic [3:0]  b_be   [8] = '{4'hF, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   spins;
    int   last_acc;
    for (int i = 0; i < 256; i++) begin
      model_a[i] = 32'd0;
      model_b[i] = 32'd0;
    end
    a_if.Req = 1'b0; a_if.ReqWrite = 1'b0; a_if.Address = 32'd0;
    a_if.WriteData = 32'd0; a_if.ByteEnable = 4'd0; a_if.RespReady = 1'b1;
    b_if.Req = 1'b0; b_if.ReqWrite = 1'b0; b_if.Address = 32'd0;
    b_if.WriteData = 32'd0; b_if.ByteEnable = 4'd0; b_if.RespReady = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(a_if.ReqReady), 32'd0);
    check("rst valid", 32'(a_if.RespValid), 32'd0);
    check("rst busy", 32'(a_if.Busy), 32'd0);
    check("rst data", a_if.ReadData, 32'd0);
    check("rst err", 32'(a_if.RespError), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", 32'(a_if.ReqReady), 32'd1);

    // Full write, read back, byte lanes, errors, backpressure
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "wr 0x10");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd 0x10");
    txn_a(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, "wr lanes 0x10");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd lanes 0x10");
    txn_a(1'b1, 32'h13, 32'h9999_9999, 4'hF, 0, "wr misaligned");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd after err");
    txn_a(1'b0, 32'h400, 32'h0, 4'h0, 0, "rd out of range");
    txn_a(1'b1, 32'h8000_0010, 32'h7777_7777, 4'hF, 0, "wr upper bit");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 5, "rd backpressure");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd after stray req");

    // Reset during WAIT of a write must drop it uncommitted
    @(negedge clk);
    a_if.Req = 1'b1; a_if.ReqWrite = 1'b1; a_if.Address = 32'h20;
    a_if.WriteData = 32'hCAFE_F00D; a_if.ByteEnable = 4'hF;
    check("midrst req_ready", 32'(a_if.ReqReady), 32'd1);
    @(posedge clk);
    #1 a_if.Req = 1'b0;
    @(negedge clk);
    check("midrst wait busy", 32'(a_if.Busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 32'(a_if.Busy), 32'd0);
    check("midrst valid", 32'(a_if.RespValid), 32'd0);
    check("midrst req_ready in reset", 32'(a_if.ReqReady), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst req_ready after", 32'(a_if.ReqReady), 32'd1);
    check("midrst no resp", 32'(a_if.RespValid), 32'd0);
    $display("A reset during WAIT of wr 0x20 data=0xcafef00d");
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd 0x20 after reset");

    // WAIT_STATES=0: Req held high, RespReady tied high
    last_acc = 0;
    @(negedge clk);
    b_if.Req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_if.ReqWrite   = b_wr[k];
      b_if.Address    = b_addr[k];
      b_if.WriteData  = b_data[k];
      b_if.ByteEnable = b_be[k];
      spins = 0;
      while (!b_if.ReqReady && spins < 10) begin
        @(negedge clk);
        spins++;
      end
      check($sformatf("B%0d req_ready", k), 32'(b_if.ReqReady), 32'd1);
      @(posedge clk);
      sb_b.push_back(model_access(1'b1, b_wr[k], b_addr[k], b_data[k], b_be[k]));
      if (k > 0) check($sformatf("B%0d accept spacing", k), 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      @(negedge clk);
      check($sformatf("B%0d valid", k), 32'(b_if.RespValid), 32'd1);
      check($sformatf("B%0d req_ready in resp", k), 32'(b_if.ReqReady), 32'd0);
      e = sb_b.pop_front();
      check($sformatf("B%0d data", k), b_if.ReadData, e.data);
      check($sformatf("B%0d err", k), 32'(b_if.RespError), 32'(e.err));
      $display("B%0d wr=%0b addr=0x%08h wdata=0x%08h be=%04b -> data=0x%08h err=%0b",
               k, b_wr[k], b_addr[k], b_data[k], b_be[k], b_if.ReadData, b_if.RespError);
      @(negedge clk);
    end
    b_if.Req = 1'b0;
    @(negedge clk);
    check("B idle busy", 32'(b_if.Busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
